// File: rtl/m_shiftseq_pkg.sv
// Shared definitions for the midgetv serial-shift sequencer: FSM encodings and
// the byte-lane alignment constant.
package m_shiftseq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    // A byte offset becomes a shift count of boff*8, i.e. boff << 3.
    localparam int BYTE_SHIFT = 3;

    localparam int CNTW_DEFAULT = 5;

endpackage

// File: rtl/m_shiftseq_cnt.sv
// Shift-amount down counter with load/decrement/clear and is-one/is-zero
// detection feeding the shift FSM.
module m_shiftseq_cnt
    import m_shiftseq_pkg::*;
#(
    parameter int CNTW = CNTW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic            dec,
    input  logic [CNTW-1:0] load_val,
    output logic [CNTW-1:0] cnt,
    output logic            is_one,
    output logic            is_zero
);

    // Clear wins over load, load wins over decrement.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - CNTW'(1);
        end
    end

    assign is_one  = (cnt == CNTW'(1));
    assign is_zero = (cnt == '0);

endmodule

// File: rtl/m_shiftseq.sv
// Serial-shift sequencer: accepts a shift request, issues exactly N single-bit
// shift enables, then pulses done. All outputs decode registered state only.
module m_shiftseq
    import m_shiftseq_pkg::*;
#(
    parameter int CNTW = CNTW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            bytemode,
    input  logic [CNTW-1:0] shamt,
    input  logic [1:0]      boff,
    input  logic            dir_in,
    input  logic            arith_in,
    input  logic            abort,
    output logic            ready,
    output logic            sh_en,
    output logic            sh_dir,
    output logic            sh_arith,
    output logic            lastshift,
    output logic            done,
    output logic            r_issh0_not,
    output logic [CNTW-1:0] dbg_cnt
);

    // Handshake: a request is taken on a clock edge where start=1 and ready=1
    // and abort=0; otherwise it is dropped and the requester must retry.

    state_t          state;
    state_t          state_nxt;
    logic            cnt_clr;
    logic            cnt_load;
    logic            cnt_dec;
    logic [CNTW-1:0] cnt;
    logic            cnt_one;
    logic            cnt_zero;
    logic [CNTW-1:0] load_val;
    logic            load_zero;
    logic            accept;

    assign load_val  = bytemode ? (CNTW'(boff) << BYTE_SHIFT) : shamt;
    assign load_zero = (load_val == '0);
    assign accept    = (state == S_IDLE) && start && !abort;

    m_shiftseq_cnt #(
        .CNTW (CNTW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (load_val),
        .cnt      (cnt),
        .is_one   (cnt_one),
        .is_zero  (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            S_IDLE: begin
                if (abort) begin
                    cnt_clr = 1'b1;
                end else if (start) begin
                    cnt_load  = 1'b1;
                    state_nxt = load_zero ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    // The zero guard keeps the counter from ever wrapping.
                    cnt_dec = !cnt_zero;
                    if (cnt_one || cnt_zero) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                cnt_clr   = abort;
                state_nxt = S_IDLE;
            end
            default: begin
                cnt_clr   = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Direction, arithmetic flag and zero-shift flag hold until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_dir      <= 1'b0;
            sh_arith    <= 1'b0;
            r_issh0_not <= 1'b1;
        end else if (accept) begin
            sh_dir      <= dir_in;
            sh_arith    <= arith_in & dir_in;
            r_issh0_not <= !load_zero;
        end
    end

    assign ready     = (state == S_IDLE);
    assign sh_en     = (state == S_SHIFT);
    assign lastshift = (state == S_SHIFT) && cnt_one;
    assign done      = (state == S_DONE);
    assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_m_shiftseq.sv
// Directed bench for m_shiftseq: each step drives inputs just after a rising
// edge and checks registered outputs in the same window.
module tb_m_shiftseq;

    localparam int CNTW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            bytemode;
    logic [CNTW-1:0] shamt;
    logic [1:0]      boff;
    logic            dir_in;
    logic            arith_in;
    logic            abort;
    logic            ready;
    logic            sh_en;
    logic            sh_dir;
    logic            sh_arith;
    logic            lastshift;
    logic            done;
    logic            r_issh0_not;
    logic [CNTW-1:0] dbg_cnt;

    int n_pass  = 0;
    int n_total = 0;

    m_shiftseq #(.CNTW(CNTW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bytemode    (bytemode),
        .shamt       (shamt),
        .boff        (boff),
        .dir_in      (dir_in),
        .arith_in    (arith_in),
        .abort       (abort),
        .ready       (ready),
        .sh_en       (sh_en),
        .sh_dir      (sh_dir),
        .sh_arith    (sh_arith),
        .lastshift   (lastshift),
        .done        (done),
        .r_issh0_not (r_issh0_not),
        .dbg_cnt     (dbg_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a request for one cycle; returns in cycle T+1.
    task automatic issue(input logic bm, input logic [1:0] bo, input logic [CNTW-1:0] amt,
                         input logic dir, input logic ar);
        bytemode = bm;
        boff     = bo;
        shamt    = amt;
        dir_in   = dir;
        arith_in = ar;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Called in cycle T+1; checks T+1..T+n shifts, done at T+n+1, ready at T+n+2.
    task automatic expect_shift(input string tag, input int n, input logic exp_dir,
                                input logic exp_arith, input logic exp_nz);
        for (int i = 1; i <= n; i++) begin
            chk({tag, "_sh_en"}, 32'(sh_en), 32'd1);
            chk({tag, "_last"}, 32'(lastshift), 32'(i == n));
            chk({tag, "_done_early"}, 32'(done), 32'd0);
            chk({tag, "_ready_busy"}, 32'(ready), 32'd0);
            chk({tag, "_cnt"}, 32'(dbg_cnt), 32'(n - i + 1));
            chk({tag, "_dir"}, 32'(sh_dir), 32'(exp_dir));
            chk({tag, "_arith"}, 32'(sh_arith), 32'(exp_arith));
            step();
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_sh_en_off"}, 32'(sh_en), 32'd0);
        chk({tag, "_ready_done"}, 32'(ready), 32'd0);
        chk({tag, "_issh0"}, 32'(r_issh0_not), 32'(exp_nz));
        step();
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        chk({tag, "_cnt_end"}, 32'(dbg_cnt), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bytemode = 1'b0; shamt = '0; boff = 2'b00;
        dir_in = 1'b0; arith_in = 1'b0; abort = 1'b0;
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_sh_en", 32'(sh_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_last", 32'(lastshift), 32'd0);
        chk("rst_issh0", 32'(r_issh0_not), 32'd1);
        chk("rst_cnt", 32'(dbg_cnt), 32'd0);
        chk("rst_dir", 32'(sh_dir), 32'd0);
        chk("rst_arith", 32'(sh_arith), 32'd0);

        // Right arithmetic shift by 5.
        issue(1'b0, 2'b00, 5'd5, 1'b1, 1'b1);
        expect_shift("sh5", 5, 1'b1, 1'b1, 1'b1);

        // Zero shift: done immediately, zero flag sticks until next accept.
        issue(1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
        expect_shift("sh0", 0, 1'b0, 1'b0, 1'b0);
        step();
        chk("sh0_issh0_hold", 32'(r_issh0_not), 32'd0);
        chk("sh0_dir_hold", 32'(sh_dir), 32'd0);

        // Maximum shift, left: arith request must be ignored.
        issue(1'b0, 2'b00, 5'd31, 1'b0, 1'b1);
        expect_shift("sh31", 31, 1'b0, 1'b0, 1'b1);

        // Byte lane 3: 24 shifts, shamt ignored.
        issue(1'b1, 2'b11, 5'd1, 1'b1, 1'b0);
        expect_shift("byte3", 24, 1'b1, 1'b0, 1'b1);

        // Byte lane 0: zero-shift path.
        issue(1'b1, 2'b00, 5'd5, 1'b0, 1'b0);
        expect_shift("byte0", 0, 1'b0, 1'b0, 1'b0);

        // Abort at T+4 of a 10-shift.
        issue(1'b0, 2'b00, 5'd10, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            chk("abort_sh_en", 32'(sh_en), 32'd1);
            step();
        end
        chk("abort_sh_en_t4", 32'(sh_en), 32'd1);
        chk("abort_cnt_t4", 32'(dbg_cnt), 32'd7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_sh_en_off", 32'(sh_en), 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_cnt_clr", 32'(dbg_cnt), 32'd0);
        issue(1'b0, 2'b00, 5'd2, 1'b1, 1'b0);
        expect_shift("after_abort", 2, 1'b1, 1'b0, 1'b1);

        // start during SHIFT and DONE is ignored.
        issue(1'b0, 2'b00, 5'd4, 1'b1, 1'b0);
        shamt = 5'd9; dir_in = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_cnt_t2", 32'(dbg_cnt), 32'd3);
        chk("ign_dir_t2", 32'(sh_dir), 32'd1);
        step();
        step();
        chk("ign_last_t4", 32'(lastshift), 32'd1);
        step();
        chk("ign_done_t5", 32'(done), 32'd1);
        shamt = 5'd7; start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_ready_t6", 32'(ready), 32'd1);
        chk("ign_sh_en_t6", 32'(sh_en), 32'd0);
        chk("ign_cnt_t6", 32'(dbg_cnt), 32'd0);
        chk("ign_dir_t6", 32'(sh_dir), 32'd1);

        // start together with abort in IDLE is dropped.
        shamt = 5'd6; dir_in = 1'b0; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("sa_ready", 32'(ready), 32'd1);
        chk("sa_sh_en", 32'(sh_en), 32'd0);
        chk("sa_cnt", 32'(dbg_cnt), 32'd0);
        chk("sa_dir", 32'(sh_dir), 32'd1);
        step();
        chk("sa_done", 32'(done), 32'd0);
        chk("sa_sh_en2", 32'(sh_en), 32'd0);

        // Reset in the middle of a shift, after a zero shift cleared the flag.
        issue(1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
        step();
        issue(1'b0, 2'b00, 5'd8, 1'b1, 1'b1);
        step();
        chk("mr_sh_en", 32'(sh_en), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_ready", 32'(ready), 32'd1);
        chk("mr_sh_en_off", 32'(sh_en), 32'd0);
        chk("mr_cnt", 32'(dbg_cnt), 32'd0);
        chk("mr_dir", 32'(sh_dir), 32'd0);
        chk("mr_arith", 32'(sh_arith), 32'd0);
        chk("mr_issh0", 32'(r_issh0_not), 32'd1);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_last", 32'(lastshift), 32'd0);
        step();
        chk("mr_stay_idle", 32'(ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
